// File: rtl/serial_compare_ctrl_pkg.sv
// serial_compare_ctrl_pkg: FSM state encoding and one-hot compare result constants.
package serial_compare_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_e;
  localparam logic [2:0] CMP_GT = 3'b100;
  localparam logic [2:0] CMP_LT = 3'b010;
  localparam logic [2:0] CMP_EQ = 3'b001;
endpackage

// File: rtl/serial_compare_ctrl_if.sv
// serial_compare_ctrl_if: start/operand request and ready/done/result response bundle.
interface serial_compare_ctrl_if #(parameter int WIDTH = 32) ();
  logic             iStart;
  logic [WIDTH-1:0] iData_a;
  logic [WIDTH-1:0] iData_b;
  logic             oReady;
  logic             oDone;
  logic [2:0]       oData;
  modport master (output iStart, iData_a, iData_b, input oReady, oDone, oData);
  modport slave (input iStart, iData_a, iData_b, output oReady, oDone, oData);
endinterface

// File: rtl/serial_compare_ctrl_step.sv
// compare_nibble_step: one LSB-first cascade step; a differing nibble overrides lower-order history.
module compare_nibble_step
  import serial_compare_ctrl_pkg::*;
(
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic [2:0] casc_i,
  output logic [2:0] casc_o
);
  always_comb begin
    casc_o = (a_i > b_i) ? CMP_GT : (a_i < b_i) ? CMP_LT : casc_i;
  end
endmodule

// File: rtl/serial_compare_ctrl.sv
// serial_compare_ctrl: nibble-serial magnitude compare, N=WIDTH/4 RUN cycles per operation.
// Define SIGNED_CMP_EN for two's-complement compare (sign bits inverted at operand latch).
module serial_compare_ctrl
  import serial_compare_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic                iClk,
  input logic                iRst,
  serial_compare_ctrl_if.slave bus
);
  localparam int N  = WIDTH / 4;
  localparam int CW = $clog2(N);
  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, a_in, b_in;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       casc_q, casc_d, data_q, data_d, step;
  logic             accept, run, last;
`ifdef SIGNED_CMP_EN
  localparam logic [WIDTH-1:0] SIGN_FLIP = {1'b1, {(WIDTH-1){1'b0}}};
  assign a_in = bus.iData_a ^ SIGN_FLIP;
  assign b_in = bus.iData_b ^ SIGN_FLIP;
`else
  assign a_in = bus.iData_a;
  assign b_in = bus.iData_b;
`endif
  compare_nibble_step u_step (
    .a_i    (a_q[3:0]),
    .b_i    (b_q[3:0]),
    .casc_i (casc_q),
    .casc_o (step)
  );
  always_ff @(posedge iClk) begin
    if (iRst) state_q <= IDLE;
    else      state_q <= state_d;
  end
  always_comb begin
    accept  = (state_q == IDLE) && bus.iStart;
    run     = (state_q == RUN);
    last    = run && (cnt_q == CW'(N - 1));
    state_d = (state_q == IDLE) ? (bus.iStart ? RUN : IDLE) :
              run               ? (last ? DONE : RUN) : IDLE;
  end
  always_comb begin
    bus.oReady = (state_q == IDLE);
    bus.oDone  = (state_q == DONE);
    bus.oData  = data_q;
  end
  // Operands shift right so only the low nibble ever reaches the step logic.
  always_comb begin
    a_d    = accept ? a_in : run ? (a_q >> 4) : a_q;
    b_d    = accept ? b_in : run ? (b_q >> 4) : b_q;
    cnt_d  = accept ? '0 : run ? cnt_q + CW'(1) : cnt_q;
    casc_d = accept ? CMP_EQ : run ? step : casc_q;
    data_d = last ? step : data_q;
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      a_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      casc_q <= CMP_EQ;
      data_q <= 3'b000;
    end else begin
      a_q    <= a_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      casc_q <= casc_d;
      data_q <= data_d;
    end
  end
endmodule

// File: tb/tb_serial_compare_ctrl.sv
// tb_serial_compare_ctrl: directed vectors with hand-computed results, latency and reset checks.
module tb_serial_compare_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  always #5 clk = ~clk;
  serial_compare_ctrl_if #(.WIDTH(32)) bus ();
  serial_compare_ctrl #(.WIDTH(32)) dut (.iClk(clk), .iRst(rst), .bus(bus));
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  // Called at a negedge in IDLE; start is sampled at the next edge (cycle 0).
  task automatic do_cmp(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic [2:0] exp, input bit noisy);
    int lat;
    lat = 0;
    check({tag, "_ready"}, 32'(bus.oReady), 32'd1);
    bus.iStart = 1'b1;
    bus.iData_a = a;
    bus.iData_b = b;
    do begin
      @(negedge clk);
      lat++;
      bus.iStart = noisy ? 1'($urandom) : 1'b0;
      if (noisy) begin
        bus.iData_a = $urandom;
        bus.iData_b = $urandom;
      end
    end while (!bus.oDone && lat < 20);
    bus.iStart = 1'b0;
    check({tag, "_lat"}, 32'(lat), 32'd9);
    check({tag, "_data"}, 32'(bus.oData), 32'(exp));
    @(negedge clk);
    check({tag, "_ready_back"}, 32'(bus.oReady), 32'd1);
    check({tag, "_done_pulse"}, 32'(bus.oDone), 32'd0);
    check({tag, "_held"}, 32'(bus.oData), 32'(exp));
    @(negedge clk);
    check({tag, "_no_queue"}, 32'(bus.oReady), 32'd1);
  endtask
  initial begin
    logic [2:0] exp_q[$];
    logic [2:0] want;
    int last_t, dones;
    bit alt, seen;
    bus.iStart = 1'b0;
    bus.iData_a = '0;
    bus.iData_b = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.oReady), 32'd1);
    check("rst_done", 32'(bus.oDone), 32'd0);
    check("rst_data", 32'(bus.oData), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    do_cmp("eq", 32'h12345678, 32'h12345678, 3'b001, 1'b0);
    do_cmp("gt_msn", 32'h10000000, 32'h0FFFFFFF, 3'b100, 1'b0);
    do_cmp("lt_carry", 32'h0000000F, 32'h00000010, 3'b010, 1'b0);
`ifdef SIGNED_CMP_EN
    do_cmp("sign_min", 32'h80000000, 32'h00000001, 3'b010, 1'b0);
    do_cmp("sign_neg1", 32'hFFFFFFFF, 32'h00000000, 3'b010, 1'b0);
`else
    do_cmp("sign_min", 32'h80000000, 32'h00000001, 3'b100, 1'b0);
    do_cmp("sign_neg1", 32'hFFFFFFFF, 32'h00000000, 3'b100, 1'b0);
`endif
    do_cmp("noisy", 32'hDEADBEEF, 32'hDEADBEF0, 3'b010, 1'b1);
    // iStart held high: accepted only when ready, one result every 10 cycles.
    bus.iStart = 1'b1;
    last_t = -1;
    dones = 0;
    alt = 1'b0;
    for (int t = 0; t < 40; t++) begin
      if (bus.oDone) begin
        want = (exp_q.size() > 0) ? exp_q.pop_front() : 3'b111;
        check("hold_data", 32'(bus.oData), 32'(want));
        if (last_t >= 0) check("hold_period", 32'(t - last_t), 32'd10);
        last_t = t;
        dones++;
      end
      if (bus.oReady) begin
        bus.iData_a = alt ? 32'd3 : 32'd5;
        bus.iData_b = alt ? 32'd5 : 32'd3;
        exp_q.push_back(alt ? 3'b010 : 3'b100);
        alt = ~alt;
      end
      @(negedge clk);
    end
    bus.iStart = 1'b0;
    check("hold_dones", 32'(dones), 32'd4);
    @(negedge clk);
    // Reset in RUN cycle 4 aborts without a done pulse.
    bus.iStart = 1'b1;
    bus.iData_a = 32'h00000009;
    bus.iData_b = 32'h00000001;
    @(negedge clk);
    bus.iStart = 1'b0;
    check("abort_busy", 32'(bus.oReady), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_ready", 32'(bus.oReady), 32'd1);
    check("abort_done", 32'(bus.oDone), 32'd0);
    check("abort_data", 32'(bus.oData), 32'd0);
    seen = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      seen |= bus.oDone;
    end
    check("abort_no_done", 32'(seen), 32'd0);
    do_cmp("after_abort", 32'h00000009, 32'h00000001, 3'b100, 1'b0);
    // Reset wins over a simultaneous start.
    rst = 1'b1;
    bus.iStart = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.iStart = 1'b0;
    check("rst_prio_ready", 32'(bus.oReady), 32'd1);
    @(negedge clk);
    check("rst_prio_idle", 32'(bus.oReady), 32'd1);
    check("rst_prio_data", 32'(bus.oData), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
